traffic_conflict_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 22 ++
 rtl/traffic_conflict_monitor_light_watch.sv | 63 ++++++
 rtl/traffic_conflict_monitor.sv | 93 +++++++++
 tb/tb_traffic_conflict_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings and conflict-monitor fault codes.
package traffic_pkg;

    localparam logic [3:0] LIGHT_LEFT   = 4'b1001;
    localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
    localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
    localparam logic [3:0] LIGHT_RED    = 4'b0001;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_CONFLICT   = 3'd1,
        FC_ENCODING   = 3'd2,
        FC_TRANSITION = 3'd3,
        FC_STUCK      = 3'd4
    } fault_code_t;

    function automatic logic light_legal(input logic [3:0] l);
        return (l == LIGHT_LEFT) || (l == LIGHT_GREEN) ||
               (l == LIGHT_YELLOW) || (l == LIGHT_RED);
    endfunction

endpackage

// File: rtl/traffic_conflict_monitor_light_watch.sv
// Per-direction history: previous sample, dwell counter and
// encoding / transition / stuck flags for the current sample.
module light_watch
    import traffic_pkg::*;
#(
    parameter int STUCK_MAX = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] light,
    input  logic       emg_hist,
    output logic       bad_code,
    output logic       bad_step,
    output logic       stuck
);

    localparam int CW = $clog2(STUCK_MAX + 2);
    localparam logic [CW-1:0] SAT = CW'(STUCK_MAX + 1);

    logic [3:0]    prev;
    logic          valid;
    logic [CW-1:0] dwell;
    logic [CW-1:0] dwell_next;
    logic          changed;
    logic          step_ok;

    assign changed  = valid && (light != prev);
    assign bad_code = !light_legal(light);

    // RED->anything is only a resume from all-stop when emergency was recent
    assign step_ok =
        (prev == LIGHT_LEFT   && light == LIGHT_GREEN)  ||
        (prev == LIGHT_GREEN  && light == LIGHT_YELLOW) ||
        (prev == LIGHT_YELLOW && light == LIGHT_RED)    ||
        (prev == LIGHT_RED    && light == LIGHT_LEFT)   ||
        (light == LIGHT_RED) ||
        (prev == LIGHT_RED && light_legal(light) && emg_hist);

    assign bad_step = changed && !step_ok;

    always_comb begin
        dwell_next = dwell;
        if (!valid || light != prev)
            dwell_next = CW'(1);
        else if (dwell != SAT)
            dwell_next = dwell + 1'b1;
    end

    assign stuck = (dwell_next == SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '0;
            valid <= 1'b0;
            dwell <= '0;
        end else begin
            prev  <= light;
            valid <= 1'b1;
            dwell <= dwell_next;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Intersection safety monitor: priority-encodes violations, latches
// the first fault and forces all-stop through the emergency output.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int STUCK_MAX = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ns_light,
    input  logic [3:0] ew_light,
    input  logic       ext_emergency,
    input  logic       clear,
    output logic       emergency,
    output logic       fault,
    output logic [2:0] fault_code
);

    logic        ns_code, ns_step, ns_stuck;
    logic        ew_code, ew_step, ew_stuck;
    logic        emergency_d;
    logic        emg_hist;
    logic        conflict;
    logic        violation;
    fault_code_t viol_code;
    logic        fault_next;
    logic [2:0]  code_next;

    assign emg_hist = emergency | emergency_d;

    light_watch #(.STUCK_MAX(STUCK_MAX)) u_ns (
        .clk      (clk),
        .rst_n    (rst_n),
        .light    (ns_light),
        .emg_hist (emg_hist),
        .bad_code (ns_code),
        .bad_step (ns_step),
        .stuck    (ns_stuck)
    );

    light_watch #(.STUCK_MAX(STUCK_MAX)) u_ew (
        .clk      (clk),
        .rst_n    (rst_n),
        .light    (ew_light),
        .emg_hist (emg_hist),
        .bad_code (ew_code),
        .bad_step (ew_step),
        .stuck    (ew_stuck)
    );

    assign conflict = (ns_light != LIGHT_RED) && (ew_light != LIGHT_RED);

    always_comb begin
        viol_code = FC_NONE;
        if (conflict)
            viol_code = FC_CONFLICT;
        else if (ns_code || ew_code)
            viol_code = FC_ENCODING;
        else if (ns_step || ew_step)
            viol_code = FC_TRANSITION;
        else if (ns_stuck || ew_stuck)
            viol_code = FC_STUCK;
    end

    assign violation = (viol_code != FC_NONE);

    always_comb begin
        fault_next = fault;
        code_next  = fault_code;
        if (!fault && violation) begin
            fault_next = 1'b1;
            code_next  = viol_code;
        end else if (fault && clear && !violation) begin
            fault_next = 1'b0;
            code_next  = FC_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            emergency   <= 1'b0;
            emergency_d <= 1'b0;
        end else begin
            fault       <= fault_next;
            fault_code  <= code_next;
            emergency   <= fault_next | ext_emergency;
            emergency_d <= emergency;
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor.
module tb_traffic_conflict_monitor;

    localparam logic [3:0] L = 4'b1001;
    localparam logic [3:0] G = 4'b0100;
    localparam logic [3:0] Y = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ns_light;
    logic [3:0] ew_light;
    logic       ext_emergency;
    logic       clear;
    logic       emergency;
    logic       fault;
    logic [2:0] fault_code;

    int checks = 0;
    int errors = 0;

    traffic_conflict_monitor #(.STUCK_MAX(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .ext_emergency (ext_emergency),
        .clear         (clear),
        .emergency     (emergency),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ns_light      = R;
        ew_light      = R;
        ext_emergency = 1'b0;
        clear         = 1'b0;
        rst_n         = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || emergency !== 1'b0) begin
            errors++;
            $display("FAIL reset: fault=%b code=%0d emg=%b want 0/0/0",
                     fault, fault_code, emergency);
        end
    endtask

    task automatic test_normal();
        int p;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            p = c % 36;
            ns_light = (p < 5) ? L : (p < 15) ? G : (p < 18) ? Y : R;
            ew_light = (p < 18) ? R : (p < 23) ? L : (p < 33) ? G : Y;
            tick();
            checks++;
            if (fault !== 1'b0 || emergency !== 1'b0) begin
                errors++;
                $display("FAIL normal cyc %0d: fault=%b emg=%b code=%0d want 0/0/0",
                         c, fault, emergency, fault_code);
            end
        end
    endtask

    task automatic test_conflict_clear();
        do_reset();
        tick();
        ns_light = G;
        ew_light = L;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || emergency !== 1'b1) begin
            errors++;
            $display("FAIL conflict: fault=%b code=%0d emg=%b want 1/1/1",
                     fault, fault_code, emergency);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1) begin
            errors++;
            $display("FAIL clear_during_conflict: fault=%b code=%0d want 1/1",
                     fault, fault_code);
        end
        ns_light = R;
        ew_light = R;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || emergency !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_clear: fault=%b code=%0d emg=%b want 1/1/1",
                     fault, fault_code, emergency);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || emergency !== 1'b0) begin
            errors++;
            $display("FAIL clear: fault=%b code=%0d emg=%b want 0/0/0",
                     fault, fault_code, emergency);
        end
        ns_light = G;
        ew_light = G;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1) begin
            errors++;
            $display("FAIL refault: fault=%b code=%0d want 1/1", fault, fault_code);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || emergency !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: fault=%b code=%0d emg=%b want 0/0/0",
                     fault, fault_code, emergency);
        end
        ns_light = R;
        ew_light = R;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_bad_transition();
        do_reset();
        tick();
        ns_light = L;
        tick();
        ns_light = G;
        tick();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL legal_steps: fault=%b code=%0d want 0", fault, fault_code);
        end
        ns_light = L;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd3 || emergency !== 1'b1) begin
            errors++;
            $display("FAIL green_to_left: fault=%b code=%0d emg=%b want 1/3/1",
                     fault, fault_code, emergency);
        end
        ns_light = 4'b0110;
        tick();
        checks++;
        if (fault_code !== 3'd3) begin
            errors++;
            $display("FAIL code_held: code=%0d want 3", fault_code);
        end
    endtask

    task automatic test_priority();
        do_reset();
        tick();
        ns_light = 4'b0110;
        ew_light = G;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1) begin
            errors++;
            $display("FAIL conflict_over_enc: fault=%b code=%0d want 1/1",
                     fault, fault_code);
        end
        do_reset();
        tick();
        ns_light = 4'b0110;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd2) begin
            errors++;
            $display("FAIL encoding: fault=%b code=%0d want 1/2", fault, fault_code);
        end
    endtask

    task automatic test_resume();
        do_reset();
        tick();
        ns_light = L;
        tick();
        ns_light = G;
        tick();
        ext_emergency = 1'b1;
        tick();
        ext_emergency = 1'b0;
        checks++;
        if (emergency !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL ext_emg: emg=%b fault=%b want 1/0", emergency, fault);
        end
        ns_light = R;
        tick();
        checks++;
        if (emergency !== 1'b0) begin
            errors++;
            $display("FAIL ext_emg_fall: emg=%b want 0", emergency);
        end
        ns_light = Y;
        tick();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL resume_ok: fault=%b code=%0d want 0", fault, fault_code);
        end
        ns_light = R;
        for (int i = 0; i < 3; i++) tick();
        ns_light = Y;
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd3) begin
            errors++;
            $display("FAIL resume_stale: fault=%b code=%0d want 1/3",
                     fault, fault_code);
        end
    endtask

    task automatic test_stuck();
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL stuck_early sample %0d: fault=%b code=%0d want 0",
                         i, fault, fault_code);
            end
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd4 || emergency !== 1'b1) begin
            errors++;
            $display("FAIL stuck33: fault=%b code=%0d emg=%b want 1/4/1",
                     fault, fault_code, emergency);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd4) begin
            errors++;
            $display("FAIL stuck_clear_ignored: fault=%b code=%0d want 1/4",
                     fault, fault_code);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_conflict_clear();
        test_bad_transition();
        test_priority();
        test_resume();
        test_stuck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
